aes_key_sched_rev: RTL and testbench
====================================

# aes_key_sched_rev

Iterative AES-128 key-schedule engine that supplies round keys to the decryption datapath in reverse order, from round 10 down to round 0. It expands a 128-bit cipher key forward, one round per clock, into an internal 11-entry store. It then serves the entries through a valid/read-enable handshake. The AES decrypt core consumes it in place of on-the-fly forward expansion, and one expansion can be reused for any number of blocks.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle pulse that loads `key` and begins expansion; honoured in IDLE and SERVE, ignored in EXPAND.
- key  input  128  cipher key, sampled only on an accepted `start`; bits [127:96] are w0 and [31:0] are w3.
- rewind  input  1  in SERVE, resets the read pointer to 10.
- rk_rd_en  input  1  consumer accepts the current `rk_out`.
- busy  output  1  high while in EXPAND.
- ready  output  1  high while in SERVE, meaning all 11 round keys are valid.
- rk_valid  output  1  same as `ready`.
- rk_out  output  128  round key at the read pointer when `rk_valid` is high; 0 otherwise.
- rk_idx  output  4  read pointer value (0..10) when `rk_valid` is high; 0 otherwise.

## Operation
- States:
  - IDLE: reset state.
  - EXPAND: 10 cycles.
  - SERVE: schedule complete.
- Accepted `start`, from IDLE or SERVE:
  - mem[0] ← key; rcon ← 8'h01; round ← 1; state ← EXPAND.
  - Previous contents of mem[1..10] are don't-care from this point.
- EXPAND, each cycle, with prev = mem[round-1] = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - RotWord is a left rotate by 8 bits.
  - SubWord uses four instances of the team's combinational forward AES S-box.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - mem[round] ← {n0,n1,n2,n3}.
  - rcon ← xtime(rcon): shift left by 1, and XOR 8'h1B if bit 7 was set. Sequence is 01,02,04,08,10,20,40,80,1B,36.
  - round ← round+1.
- After writing round 10: state ← SERVE; ptr ← 10.
- SERVE:
  - `rk_out` = mem[ptr], combinational from the store.
  - A cycle with rk_rd_en=1 is a transfer. ptr decrements by 1, and 0 wraps to 10, so the next block's sequence follows without a gap.
  - `rewind`=1 forces ptr ← 10 and takes priority over rk_rd_en.
  - `start`=1 takes priority over both: state ← EXPAND and `ready` drops on the next cycle.
- `rk_rd_en` and `rewind` are ignored outside SERVE.
- `start` during EXPAND is ignored; the expansion in progress completes with the original key.
- Asynchronous reset at any time, including mid-expansion:
  - state ← IDLE; ptr ← 0; round ← 0; rcon ← 0.
  - busy, ready, rk_valid, rk_out and rk_idx all read 0.
  - The store need not be cleared, because nothing is presented until a fresh expansion completes.

## Timing
- Let edge E be the edge that samples start=1. busy=1 and ready=0 after E.
- Edges E+1..E+10 write rounds 1..10. After E+10: busy=0, ready=rk_valid=1, rk_idx=10.
- Total latency from start to ready is 11 edges.
- Throughput in SERVE is one round key per cycle, with no bubbles, including across the 0→10 wrap.
- `rk_out` and `rk_idx` change only on clock edges; there is no combinational path from rk_rd_en to rk_out.
- Restart: start in SERVE at edge S gives ready=0 after S, and ready returns after S+10.

## Test plan
- FIPS-197 vector:
  - Stimulus: reset, then start with key=2b7e151628aed2a6abf7158809cf4f3c.
  - Response: ready rises exactly 11 edges after start. First rk_out is d014f9a8c9ee2589e13f0cc8b6630ca6 (idx 10). After 9 reads, idx 1 shows a0fafe1788542cb123a339392a6c7605. The next read shows the key itself (idx 0).
- Second vector:
  - Stimulus: start with key=000102030405060708090a0b0c0d0e0f.
  - Response: idx 10 = 13111d7fe3944a17f307a78b4d2b30c5; idx 0 = the key.
- Wrap and stall:
  - Stimulus: hold rk_rd_en=1 for 22 cycles, inserting two idle (rd_en=0) cycles at idx 5.
  - Response: idx sequence is 10..0,10..0; idx and rk_out hold constant during the stall.
- Control priority:
  - Stimulus 1: in SERVE at idx 4, assert rewind together with rk_rd_en.
  - Response 1: idx becomes 10.
  - Stimulus 2: start in EXPAND with a different key.
  - Response 2: ignored; the result matches the first key.
  - Stimulus 3: start in SERVE with a new key.
  - Response 3: ready drops next cycle, then the new idx 10 key appears after 10 more edges.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously at round 6 of EXPAND.
  - Response: immediately busy=ready=rk_valid=0 and rk_out=0. After release, no output is valid until a new start completes.

Source files
------------

// File: rtl/aes_key_sched_rev.sv
// AES-128 key schedule: expands a cipher key forward into an 11-entry store,
// then serves round keys 10..0 (wrapping) to a decryption datapath.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_idx_s;

  // Entry 0 sits in the most significant byte of the table.
  assign bit_idx_s = 11'd2047 - {a_i, 3'b000};
  assign y_o       = SBOX_TABLE[bit_idx_s -: 8];

endmodule

module aes_key_sched_rev (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rewind,
  input  logic         rk_rd_en,
  output logic         busy,
  output logic         ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_SERVE  = 2'd2
  } state_e;

  state_e       state_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic [3:0]   ptr_q;
  logic         busy_q;
  logic         ready_q;
  logic [127:0] mem_q [0:10];

  logic [3:0]   prev_idx_s;
  logic [127:0] prev_rk_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  rot_s, sub_s, t_s;
  logic [31:0]  n0_s, n1_s, n2_s, n3_s;
  logic [127:0] rk_next_d;
  logic [7:0]   rcon_d;
  logic         mem_we_s;
  logic [3:0]   mem_widx_s;
  logic [127:0] mem_wdata_s;
  logic         start_ok_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Outside EXPAND round_q may be 0; clamp so the read stays in range.
  assign prev_idx_s = (round_q == 4'd0) ? 4'd0 : (round_q - 4'd1);
  assign prev_rk_s  = mem_q[prev_idx_s];
  assign {w0_s, w1_s, w2_s, w3_s} = prev_rk_s;
  assign rot_s = {w3_s[23:0], w3_s[31:24]};

  aes_sbox u_sbox0 (.a_i(rot_s[31:24]), .y_o(sub_s[31:24]));
  aes_sbox u_sbox1 (.a_i(rot_s[23:16]), .y_o(sub_s[23:16]));
  aes_sbox u_sbox2 (.a_i(rot_s[15:8]),  .y_o(sub_s[15:8]));
  aes_sbox u_sbox3 (.a_i(rot_s[7:0]),   .y_o(sub_s[7:0]));

  assign t_s       = sub_s ^ {rcon_q, 24'h000000};
  assign n0_s      = w0_s ^ t_s;
  assign n1_s      = w1_s ^ n0_s;
  assign n2_s      = w2_s ^ n1_s;
  assign n3_s      = w3_s ^ n2_s;
  assign rk_next_d = {n0_s, n1_s, n2_s, n3_s};
  assign rcon_d    = xtime(rcon_q);
  assign start_ok_s = start && (state_q != ST_EXPAND);

  // Store write port: key load on accepted start, one round per EXPAND cycle.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = 4'd0;
    mem_wdata_s = 128'd0;
    if (start_ok_s) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = 4'd0;
      mem_wdata_s = key;
    end else if (state_q == ST_EXPAND) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = round_q;
      mem_wdata_s = rk_next_d;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Round-key store; contents are only presented after a full expansion.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
      rcon_q  <= 8'h00;
      ptr_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_EXPAND;
            round_q <= 4'd1;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_EXPAND: begin
          round_q <= round_q + 4'd1;
          rcon_q  <= rcon_d;
          if (round_q == 4'd10) begin
            state_q <= ST_SERVE;
            ptr_q   <= 4'd10;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (start) begin
            state_q <= ST_EXPAND;
            round_q <= 4'd1;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else if (rewind) begin
            ptr_q <= 4'd10;
          end else if (rk_rd_en) begin
            ptr_q <= (ptr_q == 4'd0) ? 4'd10 : (ptr_q - 4'd1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign rk_valid = ready_q;
  assign rk_out   = ready_q ? mem_q[ptr_q] : 128'd0;
  assign rk_idx   = ready_q ? ptr_q : 4'd0;

endmodule

// File: tb/tb_aes_key_sched_rev.sv
// Self-checking bench for aes_key_sched_rev against a word-level FIPS-197 model.

module tb_aes_key_sched_rev;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = 128'd0;
  logic         rewind = 1'b0;
  logic         rk_rd_en = 1'b0;
  logic         busy, ready, rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  int n_checks = 0;
  int n_pass = 0;
  logic [127:0] model_rk [0:10];

  aes_key_sched_rev dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .rewind(rewind),
    .rk_rd_en(rk_rd_en), .busy(busy), .ready(ready), .rk_valid(rk_valid),
    .rk_out(rk_out), .rk_idx(rk_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box derived from the field inverse and affine map, independent of any table.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_f(tmp[31:24]), sbox_f(tmp[23:16]), sbox_f(tmp[15:8]), sbox_f(tmp[7:0])}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Pulse start for one edge and count edges (including that one) until ready.
  task automatic run_start(input logic [127:0] k, output int edges);
    key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({busy, ready, rk_valid, rk_out, rk_idx} !== 135'd0)
      $display("FAIL reset_outputs busy=%b ready=%b valid=%b out=%h idx=%0d required all 0",
               busy, ready, rk_valid, rk_out, rk_idx);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    rk_rd_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rk_rd_en = 1'b0;
    n_checks++;
    if ({busy, ready, rk_valid, rk_out, rk_idx} !== 135'd0)
      $display("FAIL idle_outputs busy=%b ready=%b out=%h idx=%0d required all 0",
               busy, ready, rk_out, rk_idx);
    else n_pass++;
  endtask

  task automatic test_fips;
    int edges;
    logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    compute_model(k);
    key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0)
      $display("FAIL fips_busy busy=%b ready=%b required 1/0", busy, ready);
    else n_pass++;
    edges = 1;
    while (!ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (edges !== 11 || busy !== 1'b0 || rk_valid !== 1'b1)
      $display("FAIL fips_latency edges=%0d busy=%b valid=%b required 11/0/1", edges, busy, rk_valid);
    else n_pass++;
    n_checks++;
    if (rk_idx !== 4'd10 || rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      $display("FAIL fips_rk10 idx=%0d out=%h required 10 d014f9a8c9ee2589e13f0cc8b6630ca6", rk_idx, rk_out);
    else n_pass++;
    for (int r = 10; r >= 0; r--) begin
      n_checks++;
      if (rk_idx !== r[3:0] || rk_out !== model_rk[r])
        $display("FAIL fips_seq idx=%0d out=%h required %0d %h", rk_idx, rk_out, r, model_rk[r]);
      else n_pass++;
      if (r == 1) begin
        n_checks++;
        if (rk_out !== 128'ha0fafe1788542cb123a339392a6c7605)
          $display("FAIL fips_rk1 out=%h required a0fafe1788542cb123a339392a6c7605", rk_out);
        else n_pass++;
      end
      if (r == 0) begin
        n_checks++;
        if (rk_out !== k) $display("FAIL fips_rk0 out=%h required %h", rk_out, k);
        else n_pass++;
      end else begin
        rk_rd_en = 1'b1;
        @(posedge clk); #1;
        rk_rd_en = 1'b0;
      end
    end
  endtask

  task automatic test_vec2;
    int edges;
    logic [127:0] k = 128'h000102030405060708090a0b0c0d0e0f;
    run_start(k, edges);
    n_checks++;
    if (edges !== 11 || rk_idx !== 4'd10 || rk_out !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
      $display("FAIL vec2_rk10 edges=%0d idx=%0d out=%h required 11 10 13111d7fe3944a17f307a78b4d2b30c5",
               edges, rk_idx, rk_out);
    else n_pass++;
    rk_rd_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rk_rd_en = 1'b0;
    n_checks++;
    if (rk_idx !== 4'd0 || rk_out !== k)
      $display("FAIL vec2_rk0 idx=%0d out=%h required 0 %h", rk_idx, rk_out, k);
    else n_pass++;
  endtask

  task automatic test_random;
    int edges;
    logic [127:0] k;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      compute_model(k);
      run_start(k, edges);
      n_checks++;
      if (edges !== 11) $display("FAIL rand_latency edges=%0d required 11", edges);
      else n_pass++;
      rk_rd_en = 1'b1;
      for (int r = 10; r >= 0; r--) begin
        n_checks++;
        if (rk_idx !== r[3:0] || rk_out !== model_rk[r])
          $display("FAIL rand_seq key=%h idx=%0d out=%h required %0d %h", k, rk_idx, rk_out, r, model_rk[r]);
        else n_pass++;
        @(posedge clk); #1;
      end
      rk_rd_en = 1'b0;
    end
  endtask

  // Continues from a schedule whose pointer has wrapped back to 10.
  task automatic test_wrap_stall;
    int exp_idx = 10;
    bit stalled = 1'b0;
    for (int t = 0; t < 22; t++) begin
      if (exp_idx == 5 && !stalled) begin
        rk_rd_en = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          n_checks++;
          if (rk_idx !== 4'd5 || rk_out !== model_rk[5])
            $display("FAIL stall_hold idx=%0d out=%h required 5 %h", rk_idx, rk_out, model_rk[5]);
          else n_pass++;
        end
        stalled = 1'b1;
      end
      n_checks++;
      if (rk_idx !== exp_idx[3:0] || rk_out !== model_rk[exp_idx])
        $display("FAIL wrap_seq t=%0d idx=%0d out=%h required %0d %h", t, rk_idx, rk_out, exp_idx, model_rk[exp_idx]);
      else n_pass++;
      rk_rd_en = 1'b1;
      @(posedge clk); #1;
      exp_idx = (exp_idx == 0) ? 10 : exp_idx - 1;
    end
    rk_rd_en = 1'b0;
    n_checks++;
    if (rk_idx !== 4'd10) $display("FAIL wrap_end idx=%0d required 10", rk_idx);
    else n_pass++;
  endtask

  task automatic test_priority;
    int edges;
    logic [127:0] ka = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] kb = ~ka;
    logic [127:0] kc = {$urandom, $urandom, $urandom, $urandom};
    rk_rd_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (rk_idx !== 4'd4) $display("FAIL prio_pre idx=%0d required 4", rk_idx);
    else n_pass++;
    rewind = 1'b1;
    @(posedge clk); #1;
    rewind = 1'b0; rk_rd_en = 1'b0;
    n_checks++;
    if (rk_idx !== 4'd10) $display("FAIL prio_rewind idx=%0d required 10", rk_idx);
    else n_pass++;
    compute_model(ka);
    key = ka; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    key = kb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 5;
    while (!ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (edges !== 11) $display("FAIL prio_ignore_latency edges=%0d required 11", edges);
    else n_pass++;
    rk_rd_en = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      n_checks++;
      if (rk_out !== model_rk[r])
        $display("FAIL prio_ignore_key idx=%0d out=%h required %h", rk_idx, rk_out, model_rk[r]);
      else n_pass++;
      @(posedge clk); #1;
    end
    rk_rd_en = 1'b0;
    compute_model(kc);
    key = kc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (ready !== 1'b0 || busy !== 1'b1 || rk_out !== 128'd0)
      $display("FAIL prio_restart_drop ready=%b busy=%b out=%h required 0/1/0", ready, busy, rk_out);
    else n_pass++;
    edges = 0;
    while (!ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (edges !== 10 || rk_idx !== 4'd10 || rk_out !== model_rk[10])
      $display("FAIL prio_restart edges=%0d idx=%0d out=%h required 10 10 %h", edges, rk_idx, rk_out, model_rk[10]);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int edges;
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, ready, rk_valid, rk_out, rk_idx} !== 135'd0)
      $display("FAIL midreset_outputs busy=%b ready=%b out=%h idx=%0d required all 0", busy, ready, rk_out, rk_idx);
    else n_pass++;
    @(posedge clk); #3;
    rst_n = 1'b1;
    rk_rd_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ready !== 1'b0 || busy !== 1'b0 || rk_out !== 128'd0)
        $display("FAIL midreset_quiet c=%0d ready=%b busy=%b out=%h required 0/0/0", c, ready, busy, rk_out);
      else n_pass++;
    end
    rk_rd_en = 1'b0;
    compute_model(k);
    run_start(k, edges);
    n_checks++;
    if (edges !== 11 || rk_out !== model_rk[10])
      $display("FAIL midreset_restart edges=%0d out=%h required 11 %h", edges, rk_out, model_rk[10]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_vec2();
    test_random();
    test_wrap_stall();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
